// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_port_arbiter_pkg;
    typedef enum logic {OWNER_FETCH, OWNER_DATA} owner_e;
    typedef enum logic {ARB_IDLE, ARB_WAIT} arb_state_e;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;
endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and the load/store
// path, tracks one outstanding fixed-latency read and routes its response.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AWIDTH     = 32,
    parameter int DWIDTH     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_valid_i,
    input  logic [AWIDTH-1:0] if_req_addr_i,
    output logic              if_req_ready_o,
    input  logic              if_flush_i,
    output logic              if_rsp_valid_o,
    output logic [DWIDTH-1:0] if_rsp_data_o,
    input  logic              d_req_valid_i,
    input  logic              d_req_we_i,
    input  logic [AWIDTH-1:0] d_req_addr_i,
    input  logic [DWIDTH-1:0] d_req_wdata_i,
    input  logic [1:0]        d_req_size_i,
    output logic              d_req_ready_o,
    output logic              d_rsp_valid_o,
    output logic [DWIDTH-1:0] d_rsp_data_o,
    output logic              mem_ren_o,
    output logic              mem_wren_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_wdata_o,
    output logic [1:0]        mem_size_o,
    input  logic [DWIDTH-1:0] mem_rdata_i
);
    localparam int LW = $clog2(MEM_LAT + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    arb_state_e    state_q, state_d;
    owner_e        owner_q, owner_d;
    logic [LW-1:0] lat_cnt_q, lat_cnt_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          flushed_q, flushed_d;

    logic rsp_cycle, can_accept, fetch_pri, grant_f, grant_d, read_grant;

    always_comb begin
        rsp_cycle  = (state_q == ARB_WAIT) && (lat_cnt_q == '0);
        can_accept = (state_q == ARB_IDLE) || rsp_cycle;
        fetch_pri  = (starve_cnt_q == SW'(STARVE_MAX)) && if_req_valid_i;
        grant_d    = can_accept && d_req_valid_i && !fetch_pri;
        grant_f    = can_accept && if_req_valid_i && !grant_d;
        read_grant = grant_f || (grant_d && !d_req_we_i);
    end

    always_comb begin
        if_req_ready_o = grant_f;
        d_req_ready_o  = grant_d;
        mem_ren_o      = read_grant;
        mem_wren_o     = grant_d && d_req_we_i;
        mem_addr_o     = '0;
        mem_wdata_o    = '0;
        mem_size_o     = '0;
        if (grant_f) begin
            mem_addr_o = if_req_addr_i;
            mem_size_o = MEM_SIZE_WORD;
        end else if (grant_d) begin
            mem_addr_o  = d_req_addr_i;
            mem_wdata_o = d_req_wdata_i;
            mem_size_o  = d_req_size_i;
        end
    end

    // A flush arriving in the response cycle itself must still kill the pulse.
    always_comb begin
        if_rsp_valid_o = rsp_cycle && (owner_q == OWNER_FETCH) && !flushed_q && !if_flush_i;
        d_rsp_valid_o  = rsp_cycle && (owner_q == OWNER_DATA);
        if_rsp_data_o  = if_rsp_valid_o ? mem_rdata_i : '0;
        d_rsp_data_o   = d_rsp_valid_o ? mem_rdata_i : '0;
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;
        flushed_d    = flushed_q;

        if (state_q == ARB_WAIT) begin
            if (lat_cnt_q != '0) lat_cnt_d = lat_cnt_q - LW'(1);
            if (owner_q == OWNER_FETCH && if_flush_i) flushed_d = 1'b1;
            if (rsp_cycle) state_d = ARB_IDLE;
        end

        // A new fetch grant starts clean even if a flush landed this cycle.
        if (grant_f) begin
            owner_d   = OWNER_FETCH;
            flushed_d = 1'b0;
        end else if (grant_d && !d_req_we_i) begin
            owner_d = OWNER_DATA;
        end
        if (read_grant) begin
            state_d   = ARB_WAIT;
            lat_cnt_d = LW'(MEM_LAT - 1);
        end

        if (!if_req_valid_i || grant_f) begin
            starve_cnt_d = '0;
        end else if (grant_d && starve_cnt_q != SW'(STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWNER_FETCH;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
            flushed_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            flushed_q    <= flushed_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed checks of mem_port_arbiter: instance 0 has MEM_LAT=1, instance 1 has MEM_LAT=3.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        if_valid[2], if_ready[2], if_flush[2], if_rsp_v[2];
    logic [31:0] if_addr[2], if_rsp_d[2];
    logic        d_valid[2], d_we[2], d_ready[2], d_rsp_v[2];
    logic [31:0] d_addr[2], d_wdata[2], d_rsp_d[2];
    logic [1:0]  d_size[2], m_size[2];
    logic        m_ren[2], m_wren[2];
    logic [31:0] m_addr[2], m_wdata[2], m_rdata[2];

    int errs = 0;
    int nchk = 0;

    mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid_i(if_valid[0]), .if_req_addr_i(if_addr[0]), .if_req_ready_o(if_ready[0]),
        .if_flush_i(if_flush[0]), .if_rsp_valid_o(if_rsp_v[0]), .if_rsp_data_o(if_rsp_d[0]),
        .d_req_valid_i(d_valid[0]), .d_req_we_i(d_we[0]), .d_req_addr_i(d_addr[0]),
        .d_req_wdata_i(d_wdata[0]), .d_req_size_i(d_size[0]), .d_req_ready_o(d_ready[0]),
        .d_rsp_valid_o(d_rsp_v[0]), .d_rsp_data_o(d_rsp_d[0]),
        .mem_ren_o(m_ren[0]), .mem_wren_o(m_wren[0]), .mem_addr_o(m_addr[0]),
        .mem_wdata_o(m_wdata[0]), .mem_size_o(m_size[0]), .mem_rdata_i(m_rdata[0])
    );

    mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) u_lat3 (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid_i(if_valid[1]), .if_req_addr_i(if_addr[1]), .if_req_ready_o(if_ready[1]),
        .if_flush_i(if_flush[1]), .if_rsp_valid_o(if_rsp_v[1]), .if_rsp_data_o(if_rsp_d[1]),
        .d_req_valid_i(d_valid[1]), .d_req_we_i(d_we[1]), .d_req_addr_i(d_addr[1]),
        .d_req_wdata_i(d_wdata[1]), .d_req_size_i(d_size[1]), .d_req_ready_o(d_ready[1]),
        .d_rsp_valid_o(d_rsp_v[1]), .d_rsp_data_o(d_rsp_d[1]),
        .mem_ren_o(m_ren[1]), .mem_wren_o(m_wren[1]), .mem_addr_o(m_addr[1]),
        .mem_wdata_o(m_wdata[1]), .mem_size_o(m_size[1]), .mem_rdata_i(m_rdata[1])
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clr(input int i);
        if_valid[i] = 0; if_addr[i] = '0; if_flush[i] = 0;
        d_valid[i] = 0; d_we[i] = 0; d_addr[i] = '0; d_wdata[i] = '0; d_size[i] = '0;
    endtask

    // Inputs change just after the falling edge; checks run 1 time unit later,
    // well before the next rising edge commits the cycle.
    task automatic next();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 0;
        for (int i = 0; i < 2; i++) begin
            clr(i);
            m_rdata[i] = '0;
        end
        next(); #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_ren%0d", i), 32'(m_ren[i]), 0);
            check($sformatf("rst_wren%0d", i), 32'(m_wren[i]), 0);
            check($sformatf("rst_rsp%0d", i), {30'd0, if_rsp_v[i], d_rsp_v[i]}, 0);
            check($sformatf("rst_addr%0d", i), m_addr[i], 0);
        end
        next(); rst_n = 1;

        // Fetch-only, MEM_LAT=1: one read per cycle.
        next(); if_valid[0] = 1; if_addr[0] = 32'h100; m_rdata[0] = 32'hDEADBEEF; #1;
        check("t1_ready", 32'(if_ready[0]), 1);
        check("t1_ren", 32'(m_ren[0]), 1);
        check("t1_addr", m_addr[0], 32'h100);
        check("t1_size", 32'(m_size[0]), 2);
        check("t1_norsp", 32'(if_rsp_v[0]), 0);
        next(); if_addr[0] = 32'h104; #1;
        check("t1_rspv", 32'(if_rsp_v[0]), 1);
        check("t1_rspd", if_rsp_d[0], 32'hDEADBEEF);
        check("t1_ready2", 32'(if_ready[0]), 1);
        check("t1_addr2", m_addr[0], 32'h104);
        next(); clr(0); #1;
        check("t1_rspv2", 32'(if_rsp_v[0]), 1);
        next(); #1;
        check("t1_idle_rspv", 32'(if_rsp_v[0]), 0);
        check("t1_idle_rspd", if_rsp_d[0], 0);

        // Simultaneous fetch and load: data wins, fetch follows.
        next(); if_valid[0] = 1; if_addr[0] = 32'h108; d_valid[0] = 1; d_addr[0] = 32'h200;
        d_size[0] = 2'b00; m_rdata[0] = 32'hCAFE0001; #1;
        check("t2_dready", 32'(d_ready[0]), 1);
        check("t2_ifready", 32'(if_ready[0]), 0);
        check("t2_addr", m_addr[0], 32'h200);
        check("t2_size", 32'(m_size[0]), 0);
        next(); d_valid[0] = 0; #1;
        check("t2_drspv", 32'(d_rsp_v[0]), 1);
        check("t2_drspd", d_rsp_d[0], 32'hCAFE0001);
        check("t2_ifrsp_off", 32'(if_rsp_v[0]), 0);
        check("t2_ifready2", 32'(if_ready[0]), 1);
        check("t2_addr2", m_addr[0], 32'h108);
        next(); clr(0); #1;
        check("t2_ifrspv", 32'(if_rsp_v[0]), 1);
        check("t2_drsp_off", 32'(d_rsp_v[0]), 0);
        next();

        // Starvation: four data wins, then fetch is forced through.
        if_valid[0] = 1; if_addr[0] = 32'h10C; d_valid[0] = 1; d_addr[0] = 32'h300;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("t3_dwin%0d", k), 32'(d_ready[0]), 1);
            check($sformatf("t3_fblk%0d", k), 32'(if_ready[0]), 0);
            next();
        end
        #1;
        check("t3_fwin", 32'(if_ready[0]), 1);
        check("t3_dblk", 32'(d_ready[0]), 0);
        check("t3_faddr", m_addr[0], 32'h10C);
        next(); #1;
        check("t3_starve0", 32'(u_lat1.starve_cnt_q), 0);
        check("t3_dwin_again", 32'(d_ready[0]), 1);
        next(); clr(0);
        next(); next();

        // MEM_LAT=3 with flush: fetch response dropped, data waits out latency.
        if_valid[1] = 1; if_addr[1] = 32'h300; m_rdata[1] = 32'h55AA55AA; #1;
        check("t4_fready", 32'(if_ready[1]), 1);
        next(); clr(1); d_valid[1] = 1; d_addr[1] = 32'h400; d_size[1] = 2'b10; #1;
        check("t4_dwait1", 32'(d_ready[1]), 0);
        check("t4_noren1", 32'(m_ren[1]), 0);
        next(); if_flush[1] = 1; #1;
        check("t4_dwait2", 32'(d_ready[1]), 0);
        next(); if_flush[1] = 0; #1;
        check("t4_flushed", 32'(if_rsp_v[1]), 0);
        check("t4_flushed_d", if_rsp_d[1], 0);
        check("t4_dready", 32'(d_ready[1]), 1);
        check("t4_ren", 32'(m_ren[1]), 1);
        check("t4_addr", m_addr[1], 32'h400);
        next(); clr(1); #1;
        check("t4_lat1", 32'(d_rsp_v[1]), 0);
        next(); #1;
        check("t4_lat2", 32'(d_rsp_v[1]), 0);
        next(); #1;
        check("t4_drspv", 32'(d_rsp_v[1]), 1);
        check("t4_drspd", d_rsp_d[1], 32'h55AA55AA);
        check("t4_ifrsp_off", 32'(if_rsp_v[1]), 0);
        next();

        // Back-to-back stores.
        d_valid[0] = 1; d_we[0] = 1; d_addr[0] = 32'h40; d_wdata[0] = 32'h12345678; d_size[0] = 2'b10; #1;
        check("t5_wren0", 32'(m_wren[0]), 1);
        check("t5_ren0", 32'(m_ren[0]), 0);
        check("t5_addr0", m_addr[0], 32'h40);
        check("t5_wdata0", m_wdata[0], 32'h12345678);
        check("t5_dready0", 32'(d_ready[0]), 1);
        next(); d_addr[0] = 32'h44; d_wdata[0] = 32'h9ABCDEF0; #1;
        check("t5_wren1", 32'(m_wren[0]), 1);
        check("t5_wdata1", m_wdata[0], 32'h9ABCDEF0);
        check("t5_dready1", 32'(d_ready[0]), 1);
        check("t5_norsp1", 32'(d_rsp_v[0]), 0);
        check("t5_idle1", 32'(u_lat1.state_q == ARB_IDLE), 1);
        next(); clr(0); #1;
        check("t5_norsp2", 32'(d_rsp_v[0]), 0);
        check("t5_idle2", 32'(u_lat1.state_q == ARB_IDLE), 1);
        next();

        // Reset in the middle of a MEM_LAT=3 load.
        d_valid[1] = 1; d_addr[1] = 32'h500; m_rdata[1] = 32'h0BADF00D; #1;
        check("t6_dready", 32'(d_ready[1]), 1);
        next(); clr(1); rst_n = 0; #1;
        check("t6_rst_ren", 32'(m_ren[1]), 0);
        check("t6_rst_rsp", {30'd0, if_rsp_v[1], d_rsp_v[1]}, 0);
        check("t6_rst_ready", {30'd0, if_ready[1], d_ready[1]}, 0);
        next(); rst_n = 1; if_valid[1] = 1; if_addr[1] = 32'h600; #1;
        check("t6_fready", 32'(if_ready[1]), 1);
        check("t6_faddr", m_addr[1], 32'h600);
        check("t6_nodrsp0", 32'(d_rsp_v[1]), 0);
        next(); clr(1);
        for (int k = 1; k < 3; k++) begin
            #1;
            check($sformatf("t6_nodrsp%0d", k), 32'(d_rsp_v[1]), 0);
            next();
        end
        #1;
        check("t6_ifrspv", 32'(if_rsp_v[1]), 1);
        check("t6_ifrspd", if_rsp_d[1], 32'h0BADF00D);
        check("t6_nodrsp3", 32'(d_rsp_v[1]), 0);
        next();

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between instruction fetch (read-only) and the load/store path driven by the decoder's memren/memwren controls.
- Grants one request at a time and tracks the one outstanding read through a fixed-latency memory.
- Returns each response to the requester that owns it.
- Discards stale fetch responses when a redirect (pcsel) flushes the front end.

Parameters:
AWIDTH, 32, address width
DWIDTH, 32, data width
MEM_LAT, 1, memory read latency in cycles from accepted read to rdata valid; legal range >= 1
STARVE_MAX, 4, consecutive lost arbitrations after which fetch takes priority; legal range >= 1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
if_req_valid_i  in  1  fetch read request
if_req_addr_i  in  AWIDTH  fetch address
if_req_ready_o  out  1  fetch request accepted this cycle
if_flush_i  in  1  discard any outstanding fetch response
if_rsp_valid_o  out  1  fetch response pulse
if_rsp_data_o  out  DWIDTH  fetched word
d_req_valid_i  in  1  data request
d_req_we_i  in  1  1 = store, 0 = load
d_req_addr_i  in  AWIDTH  data address
d_req_wdata_i  in  DWIDTH  store data
d_req_size_i  in  2  access size (funct3[1:0]), passed through
d_req_ready_o  out  1  data request accepted this cycle
d_rsp_valid_o  out  1  load response pulse
d_rsp_data_o  out  DWIDTH  load word
mem_ren_o  out  1  memory read strobe
mem_wren_o  out  1  memory write strobe
mem_addr_o  out  AWIDTH  memory address
mem_wdata_o  out  DWIDTH  memory write data
mem_size_o  out  2  memory access size
mem_rdata_i  in  DWIDTH  memory read data, valid MEM_LAT cycles after mem_ren_o

Behaviour:
Reset:
- state = IDLE, owner = FETCH, lat_cnt = 0, starve_cnt = 0, flushed = 0.
- All outputs 0; data outputs 0.
- Reset asserted mid-read drops the read; no response is ever produced for it.

FSM states: IDLE, WAIT.
- Grant logic is combinational and evaluated only when the arbiter can accept: state == IDLE, or WAIT in its response cycle.
- Grant decision: data wins if d_req_valid_i, unless starve_cnt == STARVE_MAX and if_req_valid_i, in which case fetch wins.
- Ready is asserted only to the winner. Handshake = valid && ready.
- Memory strobes/addr/wdata/size are driven combinationally in the handshake cycle T from the winner. Mem outputs are 0 when there is no grant.
- Fetch grant: mem_ren_o = 1, mem_size_o = 2'b10, owner <= FETCH, flushed <= 0.
- Load grant: mem_ren_o = 1, owner <= DATA.
- Read grant (fetch or load): go to WAIT, lat_cnt <= MEM_LAT-1.
- Store grant: mem_wren_o = 1, stay in IDLE. There is no response for a store. Back-to-back stores are allowed every cycle.

WAIT:
- Decrement lat_cnt each cycle.
- Response cycle is T+MEM_LAT, when lat_cnt == 0.
- In the response cycle, the owner's rsp_valid pulses for 1 cycle and its rsp_data = mem_rdata_i.
- In the response cycle, a new grant may issue the same cycle. If no new read is issued, return to IDLE. Peak read throughput is 1 per MEM_LAT cycles.

rsp_data when not valid: 0.

Flush:
- if_flush_i in any WAIT cycle with owner FETCH, including the response cycle, sets or acts as flushed; if_rsp_valid_o is then suppressed.
- The arbiter still waits out the latency.
- Flush has no effect on data ownership or on a fetch grant issued in the same cycle.

Starvation:
- starve_cnt++ (saturating at STARVE_MAX) on each grant-capable cycle where if_req_valid_i is high and data wins.
- Cleared on a fetch grant or on any cycle with if_req_valid_i low.

Simultaneous valid with starve_cnt < STARVE_MAX: data wins.

Decomposition:
- Shared package constants.svh gains:
  - owner enum (OWNER_FETCH, OWNER_DATA)
  - state enum (ARB_IDLE, ARB_WAIT)
  - MEM_SIZE_WORD = 2'b10
- No sub-module. The starvation counter and latency counter live inline.

Test Plan:
1. MEM_LAT=1, fetch only at addr 0x100, mem_rdata=0xDEADBEEF -> ren at T, if_rsp_valid at T+1 with 0xDEADBEEF; next fetch accepted at T+1.
2. Fetch and load both valid at T, load addr 0x200 -> d_req_ready=1, if_req_ready=0; d_rsp_valid at T+1; fetch granted at T+1.
3. STARVE_MAX=4, fetch and data held valid continuously -> 4 data grants, then the 5th grant goes to fetch and starve_cnt returns to 0.
4. MEM_LAT=3, fetch at T, if_flush_i at T+2 -> no if_rsp_valid at T+3; a data request at T+1 waits until T+3.
5. Store at T (addr 0x40, wdata 0x12345678) followed by a store at T+1 -> mem_wren at both cycles, no d_rsp_valid, state stays IDLE.
6. MEM_LAT=3, load issued at T, rst_n low at T+1 for 1 cycle -> all outputs 0 and no d_rsp_valid afterward; a new fetch is accepted on the first cycle after release.
